// File: rtl/prio_encode_arb.sv
// prio_encode_arb: pending-request arbiter with fixed or rotating priority and a
// registered valid/ready grant handshake.
module prio_encode_arb #(
    parameter int N           = 16,
    parameter int W           = $clog2(N),
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic [N-1:0] req,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] idx,
    output logic         select
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t         state_q;
    logic [N-1:0]   pending_q, pending_d, clr;
    logic [W-1:0]   ptr_q, ptr_d, idx_q, win, cand;
    logic           valid_q, found, accept;
    assign accept    = (state_q == GRANT) && valid_q && ready;
    assign clr       = accept ? (N'(1) << idx_q) : '0;
    assign pending_d = req | (pending_q & ~clr);
    assign ptr_d     = (ROUND_ROBIN && accept) ? idx_q - W'(1) : ptr_q;
    assign select    = enable & (|pending_q);
    assign valid     = valid_q;
    assign idx       = idx_q;
    // N is a power of two, so W-bit subtraction gives the modulo-N descent from ptr
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        cand  = ptr_q;
        for (int j = 0; j < N; j++) begin
            cand = ptr_q - W'(j);
            if (!found && pending_q[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            ptr_q     <= W'(N - 1);
            idx_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            case (state_q)
                IDLE: begin
                    if (enable && |pending_q) begin
                        idx_q   <= win;
                        valid_q <= 1'b1;
                        state_q <= GRANT;
                    end else begin
                        valid_q <= 1'b0;
                    end
                end
                GRANT: begin
                    if (accept) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prio_encode_arb.sv
// tb_prio_encode_arb: directed checks of a fixed-priority and a round-robin instance
// driven from shared stimulus.
module tb_prio_encode_arb;
    localparam int N = 16;
    localparam int W = 4;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic         ready = 1'b0;
    logic [N-1:0] req = '0;
    logic         valid_f, valid_r, select_f, select_r;
    logic [W-1:0] idx_f, idx_r;
    int           total = 0;
    int           bad = 0;

    prio_encode_arb #(.N(N), .W(W), .ROUND_ROBIN(1'b0)) dut_f (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .ready(ready),
        .valid(valid_f), .idx(idx_f), .select(select_f));
    prio_encode_arb #(.N(N), .W(W), .ROUND_ROBIN(1'b1)) dut_r (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .ready(ready),
        .valid(valid_r), .idx(idx_r), .select(select_r));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; enable = 1'b0; ready = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        enable = 1'b1;
        #1;
        total++; if (valid_f !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", valid_f); end
        total++; if (idx_f !== 4'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", idx_f); end
        total++; if (select_f !== 1'b0) begin bad++; $display("FAIL reset_select got=%0h exp=0", select_f); end
        total++; if (dut_f.pending_q !== 16'h0) begin bad++; $display("FAIL reset_pending got=%0h exp=0", dut_f.pending_q); end
        total++; if (dut_r.ptr_q !== 4'd15) begin bad++; $display("FAIL reset_ptr got=%0d exp=15", dut_r.ptr_q); end
        step();
        total++; if (valid_f !== 1'b0) begin bad++; $display("FAIL reset_first_edge_valid got=%0h exp=0", valid_f); end
    endtask

    task automatic test_fixed();
        logic [W-1:0] exp_idx [4] = '{4'd15, 4'd10, 4'd5, 4'd0};
        do_reset();
        enable = 1'b1; ready = 1'b1; req = 16'h8421;
        step();
        req = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (valid_f !== 1'b1 || idx_f !== exp_idx[i]) begin bad++; $display("FAIL fixed_grant%0d got=%0h/%0d exp=1/%0d", i, valid_f, idx_f, exp_idx[i]); end
            step();
            total++; if (valid_f !== 1'b0) begin bad++; $display("FAIL fixed_gap%0d got=%0h exp=0", i, valid_f); end
        end
        total++; if (dut_f.pending_q !== 16'h0) begin bad++; $display("FAIL fixed_pending_empty got=%0h exp=0", dut_f.pending_q); end
        total++; if (dut_f.ptr_q !== 4'd15) begin bad++; $display("FAIL fixed_ptr got=%0d exp=15", dut_f.ptr_q); end
    endtask

    task automatic test_round_robin();
        logic [W-1:0] exp_idx [4] = '{4'd1, 4'd0, 4'd1, 4'd0};
        do_reset();
        enable = 1'b1; ready = 1'b1; req = 16'h0003;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (valid_r !== 1'b1 || idx_r !== exp_idx[i]) begin bad++; $display("FAIL rr_grant%0d got=%0h/%0d exp=1/%0d", i, valid_r, idx_r, exp_idx[i]); end
            step();
        end
        total++; if (dut_r.ptr_q !== 4'd15) begin bad++; $display("FAIL rr_ptr_wrap got=%0d exp=15", dut_r.ptr_q); end
        req = '0;
    endtask

    task automatic test_hold();
        do_reset();
        enable = 1'b1; req = 16'h0080;
        step();
        req = 16'h8000;
        step();
        for (int i = 0; i < 5; i++) begin
            enable = ~enable;
            step();
            total++; if (valid_f !== 1'b1 || idx_f !== 4'd7) begin bad++; $display("FAIL hold%0d got=%0h/%0d exp=1/7", i, valid_f, idx_f); end
        end
        enable = 1'b1; ready = 1'b1;
        step();
        req = '0;
        total++; if (valid_f !== 1'b0) begin bad++; $display("FAIL hold_accept got=%0h exp=0", valid_f); end
        step();
        total++; if (valid_f !== 1'b1 || idx_f !== 4'd15) begin bad++; $display("FAIL hold_next got=%0h/%0d exp=1/15", valid_f, idx_f); end
    endtask

    task automatic test_set_wins();
        do_reset();
        enable = 1'b1; req = 16'h0008;
        step();
        req = '0;
        step();
        total++; if (valid_f !== 1'b1 || idx_f !== 4'd3) begin bad++; $display("FAIL setwin_first got=%0h/%0d exp=1/3", valid_f, idx_f); end
        ready = 1'b1; req = 16'h0008;
        step();
        req = '0;
        total++; if (dut_f.pending_q !== 16'h0008) begin bad++; $display("FAIL setwin_pending got=%0h exp=0008", dut_f.pending_q); end
        step();
        total++; if (valid_f !== 1'b1 || idx_f !== 4'd3) begin bad++; $display("FAIL setwin_regrant got=%0h/%0d exp=1/3", valid_f, idx_f); end
        step();
        total++; if (dut_f.pending_q !== 16'h0) begin bad++; $display("FAIL setwin_clear got=%0h exp=0", dut_f.pending_q); end
    endtask

    task automatic test_enable();
        do_reset();
        req = 16'h0010;
        step();
        req = '0;
        step();
        total++; if (select_f !== 1'b0 || valid_f !== 1'b0) begin bad++; $display("FAIL en_off got=%0h/%0h exp=0/0", select_f, valid_f); end
        total++; if (dut_f.pending_q !== 16'h0010) begin bad++; $display("FAIL en_pending got=%0h exp=0010", dut_f.pending_q); end
        enable = 1'b1;
        #1;
        total++; if (select_f !== 1'b1) begin bad++; $display("FAIL en_select got=%0h exp=1", select_f); end
        step();
        total++; if (valid_f !== 1'b1 || idx_f !== 4'd4) begin bad++; $display("FAIL en_grant got=%0h/%0d exp=1/4", valid_f, idx_f); end
        total++; if (valid_r !== 1'b1 || idx_r !== 4'd4) begin bad++; $display("FAIL en_grant_rr got=%0h/%0d exp=1/4", valid_r, idx_r); end
    endtask

    task automatic test_async_reset();
        do_reset();
        enable = 1'b1; req = 16'h0201;
        step();
        req = '0;
        step();
        total++; if (valid_r !== 1'b1 || idx_r !== 4'd9) begin bad++; $display("FAIL areset_pre got=%0h/%0d exp=1/9", valid_r, idx_r); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (valid_r !== 1'b0 || idx_r !== 4'd0) begin bad++; $display("FAIL areset_out got=%0h/%0d exp=0/0", valid_r, idx_r); end
        total++; if (dut_r.pending_q !== 16'h0) begin bad++; $display("FAIL areset_pending got=%0h exp=0", dut_r.pending_q); end
        total++; if (dut_r.ptr_q !== 4'd15) begin bad++; $display("FAIL areset_ptr got=%0d exp=15", dut_r.ptr_q); end
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_round_robin();
        test_hold();
        test_set_wins();
        test_enable();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/prio_encode_arb.md
PRIO_ENCODE_ARB -- requirements
Module: prio_encode_arb

Interface
REQ-001 The block SHALL have parameter N, default 16, giving the request vector width; legal values are powers of two from 2 to 64.
REQ-002 The block SHALL have parameter W, default log2(N), giving the index width; W SHALL equal log2(N).
REQ-003 The block SHALL have parameter ROUND_ROBIN, default 0: 0 selects fixed priority, 1 selects rotating priority.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port enable, input, 1 bit: when high, new grants may be issued.
REQ-007 The block SHALL have port req, input, N bits: request pulses, captured into the pending register.
REQ-008 The block SHALL have port valid, output, 1 bit: a registered grant is presented on idx.
REQ-009 The block SHALL have port idx, output, W bits: index of the granted request.
REQ-010 The block SHALL have port ready, input, 1 bit: consumer accepts the grant when valid and ready are both high.
REQ-011 The block SHALL have port select, output, 1 bit: enable AND OR-reduction of pending; it is combinational, and 0 when enable is low (never high-impedance).

Function
REQ-012 pending SHALL be an N-bit register: each cycle pending[i] <= req[i] OR (pending[i] AND NOT clr[i]), where clr is one-hot at idx on the accept cycle, else zero; a new req pulse on the bit being cleared SHALL win and keep the bit set.
REQ-013 Priority pointer ptr (W bits) SHALL give the highest-priority index; priority descends ptr, ptr-1, ... 0, N-1, ... ptr+1 with modulo-N wrap.
REQ-014 With ROUND_ROBIN=0, ptr SHALL remain N-1 permanently (highest index wins).
REQ-015 With ROUND_ROBIN=1, on accept of index k, ptr SHALL become (k-1) mod N, making k the lowest priority; k=0 SHALL wrap ptr to N-1.
REQ-016 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-017 In IDLE with enable=1 and pending nonzero, the winner per REQ-013 SHALL be registered into idx, valid SHALL be set, and the FSM SHALL go to GRANT on the same edge; grant latency is 1 cycle from pending becoming nonzero.
REQ-018 Winner selection SHALL use registered pending only; req bits arriving in the same cycle SHALL be considered one cycle later.
REQ-019 In IDLE with enable=0 or pending zero, valid SHALL be 0 and idx SHALL hold its last value.
REQ-020 In GRANT, idx and valid SHALL stay stable until accept, regardless of enable, req or changes to pending.
REQ-021 On accept (valid AND ready in GRANT): pending[idx] SHALL be cleared per REQ-012, ptr SHALL be updated per REQ-014/REQ-015, valid SHALL go 0, and the FSM SHALL return to IDLE; maximum throughput is one grant per 2 cycles.
REQ-022 ready while valid=0 SHALL have no effect.

Reset
REQ-023 On rst_n low, asynchronously and independent of clk: pending=0, ptr=N-1, idx=0, valid=0, FSM=IDLE.
REQ-024 Reset asserted during GRANT SHALL drop the grant immediately without updating ptr; requests pending at that time are lost.
REQ-025 Reset deassertion SHALL be synchronised externally; the block SHALL not issue a grant on the first edge after release unless pending is already nonzero, which cannot occur.

Verification
REQ-026 N=16, fixed: req=0x8421 for one cycle, enable=1, ready=1 -> grants 15, 10, 5, 0 on valid, each 2 cycles apart; then pending=0 and valid=0.
REQ-027 N=16, ROUND_ROBIN=1: req held at 0x0003, ready=1 -> idx sequence 1,0,1,0; ptr after grant of 0 = 15.
REQ-028 Hold: grant idx=7 with ready=0 for 5 cycles while req=0x8000 and enable toggles -> idx stays 7 and valid stays 1; ready=1 -> accept, next grant is 15.
REQ-029 Set-wins: pending[3] granted and req[3]=1 on the accept cycle -> pending[3] stays 1 and 3 is granted again 2 cycles later.
REQ-030 enable=0 with req=0x0010 -> select=0 and valid=0, pending=0x0010; enable=1 -> select=1 immediately and valid=1, idx=4 one cycle later.
REQ-031 Asynchronous reset mid-GRANT (idx=9, valid=1): rst_n low between edges -> valid=0, idx=0, pending=0 before the next edge; ptr=15.
